// File: rtl/alu_cmd_initiator.sv
// alu_cmd_initiator
// Initiator-side partner of the alu block. It accepts one command at a time
// on a valid/ready port and drives the operands and opcode onto the alu.
// It holds those inputs stable while the alu pipeline settles, then
// captures the result and flags. The captured values are returned on a
// valid/ready response port. The block also keeps saturating counts of
// completed operations and of operations that returned an error.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          synchronous reset, ACTIVE-HIGH despite its name
//   cmd_valid_i    upstream command valid
//   cmd_ready_o    command accepted when high (state IDLE)
//   cmd_a_i/b_i    operands
//   cmd_op_i       opcode, passed through uninterpreted
//   alu_a_o/b_o    registered operands to the alu
//   alu_op_o       registered opcode to the alu
//   alu_*_i        result and flags from the alu
//   rsp_valid_o    response valid (held until rsp_ready_i)
//   rsp_ready_i    downstream accepts the response
//   rsp_*_o        captured result and flags
//   busy_o         high whenever the FSM is not IDLE
//   cmd_cnt_o      saturating completed-operation count
//   err_cnt_o      saturating count of captures with the error flag set
module alu_cmd_initiator #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [OP_W-1:0]   cmd_op_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  input  logic              alu_carry_i,
  input  logic              alu_error_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_carry_o,
  output logic              rsp_error_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  cmd_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LAT_LD  = 3'(ALU_LAT);

  state_t            state_r;
  logic [2:0]        wait_cnt_r;
  logic [DATA_W-1:0] alu_a_r;
  logic [DATA_W-1:0] alu_b_r;
  logic [OP_W-1:0]   alu_op_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_result_r;
  logic              rsp_zero_r;
  logic              rsp_carry_r;
  logic              rsp_error_r;
  logic [CNT_W-1:0]  cmd_cnt_r;
  logic [CNT_W-1:0]  err_cnt_r;

  // Control FSM: command load, latency wait, capture, response handshake.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r      <= IDLE;
      wait_cnt_r   <= 3'd0;
      alu_a_r      <= {DATA_W{1'b0}};
      alu_b_r      <= {DATA_W{1'b0}};
      alu_op_r     <= {OP_W{1'b0}};
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= {DATA_W{1'b0}};
      rsp_zero_r   <= 1'b0;
      rsp_carry_r  <= 1'b0;
      rsp_error_r  <= 1'b0;
      cmd_cnt_r    <= {CNT_W{1'b0}};
      err_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid_i) begin
            // alu inputs change only here, so they stay stable until the
            // next accepted command.
            alu_a_r    <= cmd_a_i;
            alu_b_r    <= cmd_b_i;
            alu_op_r   <= cmd_op_i;
            wait_cnt_r <= LAT_LD;
            state_r    <= WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          // A count of 0 means the alu output now reflects the operands
          // loaded ALU_LAT+1 edges ago.
          if (wait_cnt_r == 3'd0) begin
            rsp_result_r <= alu_result_i;
            rsp_zero_r   <= alu_zero_i;
            rsp_carry_r  <= alu_carry_i;
            rsp_error_r  <= alu_error_i;
            rsp_valid_r  <= 1'b1;
            if (cmd_cnt_r != CNT_MAX) begin
              cmd_cnt_r <= cmd_cnt_r + CNT_ONE;
            end else begin
              cmd_cnt_r <= cmd_cnt_r;
            end
            if (alu_error_i && (err_cnt_r != CNT_MAX)) begin
              err_cnt_r <= err_cnt_r + CNT_ONE;
            end else begin
              err_cnt_r <= err_cnt_r;
            end
            state_r <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
            state_r    <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o  = (state_r == IDLE);
  assign busy_o       = (state_r != IDLE);
  assign alu_a_o      = alu_a_r;
  assign alu_b_o      = alu_b_r;
  assign alu_op_o     = alu_op_r;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_result_o = rsp_result_r;
  assign rsp_zero_o   = rsp_zero_r;
  assign rsp_carry_o  = rsp_carry_r;
  assign rsp_error_o  = rsp_error_r;
  assign cmd_cnt_o    = cmd_cnt_r;
  assign err_cnt_o    = err_cnt_r;

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Directed bench for alu_cmd_initiator with a small registered alu model
// (one-cycle latency) in the loop. CNT_W is 4 so saturation is reachable.
module tb_alu_cmd_initiator;

  localparam int DATA_W  = 8;
  localparam int OP_W    = 3;
  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_BAD = 3'd7;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;
  logic              alu_error;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_carry;
  logic              rsp_error;
  logic              busy;
  logic [CNT_W-1:0]  cmd_cnt;
  logic [CNT_W-1:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  alu_cmd_initiator #(
    .DATA_W(DATA_W), .OP_W(OP_W), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero),
    .alu_carry_i(alu_carry), .alu_error_i(alu_error),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
    .rsp_carry_o(rsp_carry), .rsp_error_o(rsp_error),
    .busy_o(busy), .cmd_cnt_o(cmd_cnt), .err_cnt_o(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // alu model: returns {error, carry, zero, result}
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [8:0] w;
    logic       e;
    e = 1'b0;
    case (op)
      3'd0:    w = {1'b0, a} + {1'b0, b};
      3'd1:    w = {1'b0, a} - {1'b0, b};
      3'd2:    w = {1'b0, a & b};
      3'd3:    w = {1'b0, a | b};
      3'd4:    w = {1'b0, a ^ b};
      default: begin w = 9'd0; e = 1'b1; end
    endcase
    return {e, w[8], (w[7:0] == 8'd0), w[7:0]};
  endfunction

  // Registered alu model, one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      {alu_error, alu_carry, alu_zero, alu_result} <= 11'd0;
    end else begin
      {alu_error, alu_carry, alu_zero, alu_result} <= alu_f(alu_a, alu_b, alu_op);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issues one command just after an edge; returns edges until rsp_valid.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, output int lat);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    check("op_alu_a_held", alu_a, a);
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  logic [63:0] idle_vec;
  assign idle_vec = {rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_error,
                     alu_a, alu_b, alu_op, cmd_cnt, err_cnt, busy, ~cmd_ready};

  initial begin
    int lat;
    int cyc;
    int last;
    int nresp;
    rst_n = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = 8'd0; cmd_b = 8'd0; cmd_op = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;

    // Reset state and idle hold
    check("reset_outputs", idle_vec, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_hold", idle_vec, 64'd0);
    end

    // Single ADD: F0+20 = 10 with carry
    rsp_ready = 1'b1;
    run_cmd(8'hF0, 8'h20, OP_ADD, lat);
    check("add_latency", lat, ALU_LAT + 1);
    check("add_result", rsp_result, 8'h10);
    check("add_flags", {rsp_zero, rsp_carry, rsp_error}, 3'b010);
    check("add_cmd_cnt", cmd_cnt, 4'd1);
    check("add_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("add_rsp_done", {rsp_valid, cmd_ready}, 2'b01);

    // SUB to zero with 5 cycles of backpressure
    rsp_ready = 1'b0;
    run_cmd(8'h55, 8'h55, OP_SUB, lat);
    check("sub_latency", lat, ALU_LAT + 1);
    cmd_a = 8'hAA; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_error, cmd_ready},
            {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
      check("bp_alu_a", alu_a, 8'h55);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_accept", {rsp_valid, cmd_ready, busy}, 3'b010);
    check("bp_cmd_cnt", cmd_cnt, 4'd2);

    // Illegal opcode, then a legal ADD
    run_cmd(8'h12, 8'h34, OP_BAD, lat);
    check("bad_error", rsp_error, 1'b1);
    check("bad_counts", {cmd_cnt, err_cnt}, {4'd3, 4'd1});
    @(posedge clk); #1;
    run_cmd(8'h01, 8'h02, OP_ADD, lat);
    check("add2_result", {rsp_result, rsp_error}, {8'h03, 1'b0});
    check("add2_counts", {cmd_cnt, err_cnt}, {4'd4, 4'd1});
    @(posedge clk); #1;

    // Reset one cycle after a handshake
    cmd_a = 8'h09; cmd_b = 8'h09; cmd_op = OP_ADD; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    check("rst_mid_wait", idle_vec, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_no_rsp", idle_vec, 64'd0);
    end
    run_cmd(8'h03, 8'h04, OP_ADD, lat);
    check("post_rst_latency", lat, ALU_LAT + 1);
    check("post_rst_rsp", {rsp_result, cmd_cnt, err_cnt}, {8'h07, 4'd1, 4'd0});
    @(posedge clk); #1;

    // 20 back-to-back commands, saturation of cmd_cnt
    cmd_a = 8'h01; cmd_b = 8'h01; cmd_op = OP_ADD;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    cyc = 0; last = -1; nresp = 0;
    while (nresp < 20 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid) begin
        if (last >= 0) check("thru_gap", cyc - last, ALU_LAT + 3);
        last = cyc;
        nresp++;
        if (nresp == 20) cmd_valid = 1'b0;
      end
    end
    check("thru_count", nresp, 20);
    @(posedge clk); #1;
    check("sat_cmd_cnt", cmd_cnt, 4'hF);
    check("sat_idle", {busy, cmd_ready, rsp_valid}, 3'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_initiator.md
Name: alu_cmd_initiator

Overview:
- Initiator-side counterpart to the alu block. Accepts one operation at a time from an upstream stimulus or controller port using a valid/ready handshake.
- Drives operands and opcode onto the alu inputs and holds them stable for the alu's pipeline latency.
- Captures result and flags, then returns them on a valid/ready response port.
- Keeps saturating counts of completed operations and of operations that returned an error.

Parameters:
- DATA_W, 8, operand and result width; must match the alu.
- OP_W, 3, opcode width; must match the alu.
- ALU_LAT, 1, number of clk edges from operand change to registered alu output change; range 0..7.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous reset, active-high: asserted when 1 and sampled only on rising clk.
- cmd_valid_i  in  1  upstream command valid.
- cmd_ready_o  out  1  initiator can accept a command.
- cmd_a_i  in  DATA_W  operand A.
- cmd_b_i  in  DATA_W  operand B.
- cmd_op_i  in  OP_W  opcode, passed through unmodified.
- alu_a_o  out  DATA_W  to alu a_i.
- alu_b_o  out  DATA_W  to alu b_i.
- alu_op_o  out  OP_W  to alu op_i.
- alu_result_i  in  DATA_W  from alu result_o.
- alu_zero_i  in  1  from alu zero_o.
- alu_carry_i  in  1  from alu carry_o.
- alu_error_i  in  1  from alu error_o.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  downstream accepts response.
- rsp_result_o  out  DATA_W  captured result.
- rsp_zero_o  out  1  captured zero flag.
- rsp_carry_o  out  1  captured carry flag.
- rsp_error_o  out  1  captured error flag.
- busy_o  out  1  high in any state other than IDLE.
- cmd_cnt_o  out  CNT_W  completed-operation count.
- err_cnt_o  out  CNT_W  count of captures with error set.

Behaviour:
- All outputs are registered, except cmd_ready_o = (state==IDLE) and busy_o = (state!=IDLE).
- Reset (rst_n=1 at an edge) sets:
  - state to IDLE;
  - alu_a_o, alu_b_o, alu_op_o to 0;
  - all rsp_* outputs to 0;
  - both counters to 0.
- While reset is asserted, cmd_ready_o=1 combinationally, but no handshake takes effect because reset has priority.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Command handshake at edge E0 (cmd_valid_i & cmd_ready_o) loads cmd_a_i, cmd_b_i, cmd_op_i into the alu_*_o registers.
  - Loads the wait counter with ALU_LAT and moves to WAIT.
  - Without a handshake, alu_*_o hold their last values.
- WAIT:
  - Counter decrements once per edge.
  - At the edge where the counter is 0, i.e. edge E0+ALU_LAT+1, the block:
    - captures alu_result_i, alu_zero_i, alu_carry_i and alu_error_i into rsp_*;
    - sets rsp_valid_o;
    - increments cmd_cnt_o;
    - increments err_cnt_o if alu_error_i=1;
    - moves to RESP.
  - Command-to-response latency is therefore ALU_LAT+1 cycles after the handshake. With ALU_LAT=0 (combinational alu), capture occurs at E0+1.
- alu_*_o remain constant from E0 until the next command handshake. They are never changed during WAIT or RESP.
- RESP:
  - rsp_valid_o and all rsp_* values are held stable until rsp_ready_i=1 at an edge.
  - On that edge, rsp_valid_o clears and the state returns to IDLE.
  - The next command can handshake no earlier than the cycle after the response handshake. Back-to-back throughput is therefore one command per ALU_LAT+3 cycles with rsp_ready_i tied high.
- Counters saturate at all-ones; they do not wrap.
- Reset mid-operation, in WAIT or RESP: the operation is abandoned with no response and no counter increment. All state returns to reset values.
- cmd_valid_i while not in IDLE is ignored, since cmd_ready_o=0. The command is not consumed and not buffered.
- rsp_ready_i outside RESP has no effect.
- Opcode and operand values are never interpreted or checked. An illegal opcode is reported only via the alu's error flag.

Test Plan:
- Reset, then idle:
  - After reset, every output listed above is 0.
  - cmd_ready_o=1 and busy_o=0.
  - Holding cmd_valid_i=0 for 10 cycles keeps all outputs unchanged.
- Single ADD with ALU_LAT=1 and the alu in the loop:
  - Stimulus: a=8'hF0, b=8'h20, ADD opcode, handshake at E0, rsp_ready_i=1.
  - rsp_valid_o rises after E0+2 with result=8'h10, carry=1, zero=0, error=0.
  - cmd_cnt_o=1.
- Zero result with backpressure:
  - Stimulus: a=8'h55, b=8'h55, SUB opcode, rsp_ready_i=0 for 5 cycles.
  - result=8'h00 and zero=1 are held stable for all 5 cycles.
  - cmd_ready_o=0 throughout, even with cmd_valid_i=1.
  - Response is accepted on the first cycle with rsp_ready_i=1.
- Illegal opcode:
  - Stimulus: an opcode for which the alu asserts error_o.
  - rsp_error_o=1 and err_cnt_o increments from 0 to 1; cmd_cnt_o also increments.
  - A following legal ADD returns error=0 and err_cnt_o stays at 1.
- Reset mid-WAIT:
  - Stimulus: assert rst_n=1 one cycle after a command handshake.
  - No rsp_valid_o pulse occurs, counters are 0, and alu_*_o are 0.
  - A new command after release completes normally.
- Throughput and saturation:
  - Issue 20 back-to-back commands with rsp_ready_i=1; responses arrive exactly every ALU_LAT+3 cycles.
  - With CNT_W=4, 20 completions leave cmd_cnt_o=4'hF.
